// File: rtl/led_status_ctrl.sv
// led_status_ctrl: per-channel LED driver with runtime-selectable modes.
//
// Each of NUM_LEDS channels runs one of six modes: OFF, ON, COUNT (heartbeat
// from the top bits of a free-running counter), BLINK (tick-timed square wave),
// PWM (duty from the channel argument) or ACTIVITY (event pulse stretched over
// STRETCH ticks). Every channel resets to COUNT, which gives the same display
// as the old "led = counter top bits" logic.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   cfg_valid  configuration request
//   cfg_ready  configuration accept; low for one cycle after each transfer
//   cfg_idx    target channel; out-of-range indices are accepted and dropped
//   cfg_mode   0 OFF, 1 ON, 2 COUNT, 3 BLINK, 4 PWM, 5 ACTIVITY, 6/7 act as OFF
//   cfg_arg    BLINK half-period minus 1 (ticks) or PWM duty in [PWM_W-1:0]
//   evt        per-channel single-cycle activity pulses (already on clk)
//   tick       one-cycle strobe every PRESCALE clocks
//   led        registered LED drive, active-high
//
// PWM_W must not exceed 8, because the duty is taken from the 8-bit argument.
module led_status_ctrl #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned PWM_W    = 4,
  parameter int unsigned STRETCH  = 8,
  localparam int unsigned IdxW    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [IdxW-1:0]     cfg_idx,
  input  logic [2:0]          cfg_mode,
  input  logic [7:0]          cfg_arg,
  input  logic [NUM_LEDS-1:0] evt,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);

  localparam int unsigned PreW = $clog2(PRESCALE);
  localparam int unsigned StrW = $clog2(STRETCH + 1);

  localparam logic [PreW-1:0] PreMax  = PreW'(PRESCALE - 1);
  localparam logic [StrW-1:0] StrLoad = StrW'(STRETCH);

  typedef enum logic [2:0] {
    ModeOff      = 3'd0,
    ModeOn       = 3'd1,
    ModeCount    = 3'd2,
    ModeBlink    = 3'd3,
    ModePwm      = 3'd4,
    ModeActivity = 3'd5,
    ModeRsvd6    = 3'd6,
    ModeRsvd7    = 3'd7
  } mode_e;

  // Shared timebase
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PreW-1:0]  prescaler_q, prescaler_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             tick_q, tick_d;

  // Config handshake
  logic cfg_ready_q, cfg_ready_d;
  logic cfg_fire;

  // Per-channel state
  mode_e               mode_q      [NUM_LEDS];
  mode_e               mode_d      [NUM_LEDS];
  logic [7:0]          arg_q       [NUM_LEDS];
  logic [7:0]          arg_d       [NUM_LEDS];
  logic [7:0]          blink_cnt_q [NUM_LEDS];
  logic [7:0]          blink_cnt_d [NUM_LEDS];
  logic [StrW-1:0]     stretch_q   [NUM_LEDS];
  logic [StrW-1:0]     stretch_d   [NUM_LEDS];
  logic [NUM_LEDS-1:0] phase_q, phase_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] wr_en;

  // Timebase next state
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    // tick is registered, so it lands the cycle after the prescaler hits its top
    tick_d    = (prescaler_q == PreMax);
    if (prescaler_q == PreMax) begin
      prescaler_d = '0;
    end else begin
      prescaler_d = prescaler_q + PreW'(1);
    end
  end

  // Handshake: ready drops for exactly one cycle after each accepted transfer
  always_comb begin
    cfg_fire    = cfg_valid & cfg_ready_q;
    cfg_ready_d = ~cfg_fire;
  end

  // Per-channel next state and LED value
  always_comb begin
    wr_en   = '0;
    phase_d = phase_q;
    led_d   = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      mode_d[i]      = mode_q[i];
      arg_d[i]       = arg_q[i];
      blink_cnt_d[i] = blink_cnt_q[i];
      stretch_d[i]   = stretch_q[i];

      // Indices >= NUM_LEDS match no channel, so the transfer is simply absorbed
      wr_en[i] = cfg_fire && (32'(cfg_idx) == i);

      if (wr_en[i]) begin
        mode_d[i]      = mode_e'(cfg_mode);
        arg_d[i]       = cfg_arg;
        blink_cnt_d[i] = '0;
        phase_d[i]     = 1'b0;
        stretch_d[i]   = '0;
      end else begin
        if (mode_q[i] == ModeBlink && tick_q) begin
          if (blink_cnt_q[i] == arg_q[i]) begin
            blink_cnt_d[i] = '0;
            phase_d[i]     = ~phase_q[i];
          end else begin
            blink_cnt_d[i] = blink_cnt_q[i] + 8'd1;
          end
        end
        if (mode_q[i] == ModeActivity) begin
          // An event outranks a same-cycle tick so a retrigger always gets the full period
          if (evt[i]) begin
            stretch_d[i] = StrLoad;
          end else if (tick_q && (stretch_q[i] != '0)) begin
            stretch_d[i] = stretch_q[i] - StrW'(1);
          end
        end
      end

      case (mode_q[i])
        ModeOff:      led_d[i] = 1'b0;
        ModeOn:       led_d[i] = 1'b1;
        ModeCount:    led_d[i] = cnt_q[CNT_W - NUM_LEDS + i];
        ModeBlink:    led_d[i] = phase_q[i];
        ModePwm:      led_d[i] = (pwm_cnt_q < arg_q[i][PWM_W-1:0]);
        ModeActivity: led_d[i] = (stretch_q[i] != '0);
        default:      led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      prescaler_q <= '0;
      pwm_cnt_q   <= '0;
      tick_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
      phase_q     <= '0;
      led_q       <= '0;
      for (int i = 0; i < int'(NUM_LEDS); i++) begin
        mode_q[i]      <= ModeCount;
        arg_q[i]       <= '0;
        blink_cnt_q[i] <= '0;
        stretch_q[i]   <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      prescaler_q <= prescaler_d;
      pwm_cnt_q   <= pwm_cnt_d;
      tick_q      <= tick_d;
      cfg_ready_q <= cfg_ready_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      for (int i = 0; i < int'(NUM_LEDS); i++) begin
        mode_q[i]      <= mode_d[i];
        arg_q[i]       <= arg_d[i];
        blink_cnt_q[i] <= blink_cnt_d[i];
        stretch_q[i]   <= stretch_d[i];
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign tick      = tick_q;
  assign led       = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl. Main instance: 8 LEDs, 12-bit counter,
// PRESCALE=4, PWM_W=4, STRETCH=3. A second 9-LED instance (4-bit index) is
// used so that index 9 is representable and out of range.
module tb_led_status_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cfg_valid, cfg_ready;
  logic [2:0] cfg_idx;
  logic [2:0] cfg_mode;
  logic [7:0] cfg_arg;
  logic [7:0] evt;
  logic       tick;
  logic [7:0] led;

  logic       cfg_valid_b, cfg_ready_b;
  logic [3:0] cfg_idx_b;
  logic [2:0] cfg_mode_b;
  logic [7:0] cfg_arg_b;
  logic [8:0] evt_b;
  logic       tick_b;
  logic [8:0] led_b;

  int checks = 0;
  int errors = 0;
  int cyc;

  led_status_ctrl #(
    .NUM_LEDS(8), .CNT_W(12), .PRESCALE(4), .PWM_W(4), .STRETCH(3)
  ) dut (
    .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_mode(cfg_mode), .cfg_arg(cfg_arg), .evt(evt),
    .tick(tick), .led(led)
  );

  led_status_ctrl #(
    .NUM_LEDS(9), .CNT_W(12), .PRESCALE(4), .PWM_W(4), .STRETCH(3)
  ) dut_b (
    .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .cfg_idx(cfg_idx_b), .cfg_mode(cfg_mode_b), .cfg_arg(cfg_arg_b), .evt(evt_b),
    .tick(tick_b), .led(led_b)
  );

  always #5 clk = ~clk;

  // Edges since reset release; at the falling edge after edge k this reads k
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ceil4(input int x);
    return ((x + 3) / 4) * 4;
  endfunction

  task automatic cfg_write(input int idx, input int mode, input int arg, output int w);
    int guard = 0;
    @(negedge clk);
    while (!cfg_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!cfg_ready) chk("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_idx   = idx[2:0];
    cfg_mode  = mode[2:0];
    cfg_arg   = arg[7:0];
    @(negedge clk);
    w = cyc;  // transfer happened on edge w
    cfg_valid = 1'b0;
  endtask

  // COUNT check of all channels of both instances for n cycles
  task automatic count_run(input string name, input int n);
    int   bad_led = 0, bad_tick = 0, bad_rdy = 0, bad_b = 0;
    logic [11:0] c;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      c = 12'(cyc - 1);
      if (led !== c[11:4]) bad_led++;
      if (led_b !== c[11:3]) bad_b++;
      if (tick !== (cyc % 4 == 0) || tick_b !== (cyc % 4 == 0)) bad_tick++;
      if (cfg_ready !== 1'b1) bad_rdy++;
    end
    chk({name, "_led_mismatches"}, 32'(bad_led), 32'd0);
    chk({name, "_led_b_mismatches"}, 32'(bad_b), 32'd0);
    chk({name, "_tick_mismatches"}, 32'(bad_tick), 32'd0);
    chk({name, "_ready_mismatches"}, 32'(bad_rdy), 32'd0);
  endtask

  // One or two ACTIVITY events on ch2; first event lands on an edge E1 with
  // E1 % 4 == (start_mod + 1) % 4. Lit from E1+1 through ceil4(last event)+9.
  task automatic act_case(input string name, input int start_mod, input bit retrig);
    int w, c, e1, c2, e2, last_end, bad = 0, guard = 0;
    cfg_write(2, 5, 0, w);
    while (cyc % 4 != start_mod && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    c  = cyc;
    e1 = c + 1;
    c2 = ceil4(e1) + 5;
    e2 = c2 + 1;
    last_end = retrig ? ceil4(e2) + 9 : ceil4(e1) + 9;
    evt[2] = 1'b1;
    while (cyc < last_end + 4) begin
      @(negedge clk);
      evt[2] = retrig && (cyc == c2);
      if (led[2] !== ((cyc >= e1 + 1) && (cyc <= last_end))) bad++;
    end
    evt[2] = 1'b0;
    chk(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    int idx;
    int mode;
    int arg;
    bit noise;
    int exp_high;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int w, e1, r, bad, high, run, full, badrun, n, guard;
    bit seen_low, b, acc;
    int acc_cyc[3];
    int seq_idx[3], seq_mode[3];
    logic [11:0] c;

    tbl[0] = '{idx: 3, mode: 0, arg: 8'h00, noise: 1, exp_high: 0};   // OFF
    tbl[1] = '{idx: 3, mode: 1, arg: 8'h00, noise: 1, exp_high: 32};  // ON
    tbl[2] = '{idx: 3, mode: 6, arg: 8'h00, noise: 1, exp_high: 0};   // reserved
    tbl[3] = '{idx: 3, mode: 7, arg: 8'hFF, noise: 1, exp_high: 0};   // reserved
    tbl[4] = '{idx: 1, mode: 4, arg: 8'h00, noise: 0, exp_high: 0};   // PWM duty 0
    tbl[5] = '{idx: 1, mode: 4, arg: 8'h0F, noise: 1, exp_high: 30};  // PWM max duty
    tbl[6] = '{idx: 1, mode: 4, arg: 8'hF5, noise: 0, exp_high: 10};  // upper bits ignored
    tbl[7] = '{idx: 1, mode: 4, arg: 8'h08, noise: 0, exp_high: 16};
    tbl[8] = '{idx: 5, mode: 4, arg: 8'h01, noise: 0, exp_high: 2};
    tbl[9] = '{idx: 4, mode: 1, arg: 8'h5A, noise: 1, exp_high: 32};  // ON, stays for reset test

    resetn = 1'b0;
    cfg_valid = 1'b0; cfg_idx = '0; cfg_mode = '0; cfg_arg = '0; evt = '0;
    cfg_valid_b = 1'b0; cfg_idx_b = '0; cfg_mode_b = '0; cfg_arg_b = '0; evt_b = '0;

    #23;
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_led_b", 32'(led_b), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd0);

    @(negedge clk);
    resetn = 1'b1;
    #1 chk("ready_low_first_cycle", 32'(cfg_ready), 32'd0);
    count_run("count_seq", 4096);

    // BLINK ch0 arg=2: toggles every 3 ticks, first rising 10 edges after first tick
    cfg_write(0, 3, 2, w);
    e1 = ceil4(w);
    r  = e1 + 10;
    bad = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (led[0] !== ((cyc >= r) ? (((cyc - r) / 12) % 2 == 0) : 1'b0)) bad++;
    end
    chk("blink_arg2", 32'(bad), 32'd0);

    // PWM ch1 duty=5: 50 high in 160 cycles, every complete run 5 long
    cfg_write(1, 4, 5, w);
    high = 0; run = 0; full = 0; badrun = 0; seen_low = 1'b0;
    for (int j = 0; j < 160; j++) begin
      @(negedge clk);
      b = led[1];
      if (b) begin
        high++;
        run++;
      end else begin
        if (run > 0 && seen_low) begin
          full++;
          if (run != 5) badrun++;
        end
        run = 0;
        seen_low = 1'b1;
      end
    end
    chk("pwm5_high_count", 32'(high), 32'd50);
    chk("pwm5_bad_runs", 32'(badrun), 32'd0);
    chk("pwm5_enough_runs", 32'(full >= 9), 32'd1);

    // Static and PWM table, 32-cycle windows (two whole PWM periods)
    for (int t = 0; t < 10; t++) begin
      cfg_write(tbl[t].idx, tbl[t].mode, tbl[t].arg, w);
      high = 0;
      for (int j = 0; j < 32; j++) begin
        @(negedge clk);
        if (led[tbl[t].idx] === 1'b1) high++;
        if (tbl[t].noise) evt[tbl[t].idx] = 1'($urandom_range(0, 1));
      end
      evt = '0;
      chk($sformatf("table%0d_ch%0d_mode%0d_high", t, tbl[t].idx, tbl[t].mode),
          32'(high), 32'(tbl[t].exp_high));
    end

    act_case("act_single", 1, 1'b0);
    act_case("act_retrigger", 1, 1'b0 | 1'b1);
    act_case("act_evt_on_tick", 0, 1'b0);

    // Back-to-back on the 9-channel instance, valid held high
    seq_idx[0] = 0; seq_mode[0] = 1;
    seq_idx[1] = 1; seq_mode[1] = 0;
    seq_idx[2] = 9; seq_mode[2] = 1;
    @(negedge clk);
    cfg_valid_b = 1'b1;
    cfg_idx_b   = 4'd0;
    cfg_mode_b  = 3'd1;
    n = 0; guard = 0;
    while (n < 3 && guard < 20) begin
      acc = cfg_ready_b;
      if (acc) begin
        acc_cyc[n] = cyc;
        n++;
      end
      @(negedge clk);
      guard++;
      if (acc) begin
        if (n < 3) begin
          cfg_idx_b  = seq_idx[n][3:0];
          cfg_mode_b = seq_mode[n][2:0];
        end else begin
          cfg_valid_b = 1'b0;
        end
      end
    end
    cfg_valid_b = 1'b0;
    chk("b2b_accept_count", 32'(n), 32'd3);
    if (n == 3) begin
      chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    end
    @(negedge clk);
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      c = 12'(cyc - 1);
      if (led_b[0] !== 1'b1) bad++;
      if (led_b[1] !== 1'b0) bad++;
      if (led_b[8:2] !== c[11:5]) bad++;
    end
    chk("b2b_channels", 32'(bad), 32'd0);

    // Reset mid-BLINK with a config request pending
    @(negedge clk);
    chk("pre_reset_led4_on", 32'(led[4]), 32'd1);
    cfg_valid = 1'b1;
    cfg_idx   = 3'd3;
    cfg_mode  = 3'd1;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_led", 32'(led), 32'd0);
    chk("async_reset_led_b", 32'(led_b), 32'd0);
    chk("async_reset_tick", 32'(tick), 32'd0);
    chk("async_reset_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    resetn    = 1'b1;
    #1 chk("post_reset_ready_first", 32'(cfg_ready), 32'd0);
    count_run("post_reset_count", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
